// File: rtl/FPU_types.sv
// Shared FPU type definitions: conversion/arith status codes.
package FPU_types;
  typedef enum logic [1:0] {
    EXACT     = 2'd0,
    OVERFLOW  = 2'd1,
    UNDERFLOW = 2'd2,
    INEXACT   = 2'd3
  } g_eStatus;
endpackage

// File: rtl/fpu_to_int_converter.sv
// Team-FPU operand (s | exp[EXP_W] | mant[MANT_W], hidden 1) to signed 32-bit
// integer, truncating toward zero. Alignment is done with an iterative
// one-bit-per-cycle shifter; special classes bypass the shifter with k=0.
module fpu_to_int_converter
  import FPU_types::*;
#(
  parameter int BIAS   = 1023,
  parameter int MANT_W = 20,
  parameter int EXP_W  = 11
) (
  input  logic                      m_clk,
  input  logic                      m_reset,
  input  logic                      m_validIn,
  output logic                      m_readyOut,
  input  logic [MANT_W+EXP_W:0]     m_dataIn,
  output logic                      m_validOut,
  input  logic                      m_readyIn,
  output logic [MANT_W+EXP_W:0]     m_dataOut,
  output g_eStatus                  m_statusOut
);

  localparam int W  = 1 + EXP_W + MANT_W;
  localparam int AW = W - 1;                  // magnitude accumulator width
  localparam int CW = $clog2(MANT_W + 1);     // shift counter width

  // exponent-field landmarks: E=0, E=MANT_W (no shift), E=W-1 (edge of range)
  localparam logic [EXP_W-1:0] EF_ONE  = EXP_W'(BIAS);
  localparam logic [EXP_W-1:0] EF_NOSH = EXP_W'(BIAS + MANT_W);
  localparam logic [EXP_W-1:0] EF_TOP  = EXP_W'(BIAS + W - 1);
  localparam logic [EXP_W-1:0] EF_INF  = {EXP_W{1'b1}};

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ALIGN = 2'd1;
  localparam logic [1:0] S_SIGN  = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  logic [1:0]        state;
  logic [AW-1:0]     acc;
  logic [CW-1:0]     cnt;
  logic              dir_left;
  logic              sticky;
  logic              special;
  logic              neg;
  logic [W-1:0]      spec_data;
  g_eStatus          spec_st;

  // decode of the incoming operand
  logic              in_s;
  logic [EXP_W-1:0]  in_ef;
  logic [MANT_W-1:0] in_m;
  assign in_s  = m_dataIn[W-1];
  assign in_ef = m_dataIn[W-2:MANT_W];
  assign in_m  = m_dataIn[MANT_W-1:0];

  logic              c_special;
  logic [W-1:0]      c_data;
  g_eStatus          c_st;
  logic [CW-1:0]     c_k;
  logic              c_left;
  logic [EXP_W-1:0]  c_diff;

  // classify operand in priority order; only 0<=E<W-1 takes the shifter
  always_comb begin
    c_special = 1'b1;
    c_data    = '0;
    c_st      = EXACT;
    c_k       = '0;
    c_left    = 1'b0;
    c_diff    = '0;
    if (in_ef == '0) begin
      c_st = (in_m == '0) ? EXACT : UNDERFLOW;
    end else if (in_ef == EF_INF || in_ef > EF_TOP ||
                 (in_ef == EF_TOP && !(in_s && in_m == '0))) begin
      c_data = in_s ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
      c_st   = OVERFLOW;
    end else if (in_ef == EF_TOP) begin
      c_data = {1'b1, {(W-1){1'b0}}};          // exactly -2^(W-1)
    end else if (in_ef < EF_ONE) begin
      c_st = INEXACT;
    end else begin
      c_special = 1'b0;
      if (in_ef >= EF_NOSH) begin
        c_left = 1'b1;
        c_diff = in_ef - EF_NOSH;
      end else begin
        c_diff = EF_NOSH - in_ef;
      end
      c_k = c_diff[CW-1:0];
    end
  end

  assign m_readyOut = (state == S_IDLE);
  assign m_validOut = (state == S_DONE);

  logic [W-1:0] mag_ext;
  assign mag_ext = {1'b0, acc};

  // control FSM with accumulator, shifter and result registers
  always_ff @(posedge m_clk) begin
    if (m_reset) begin
      state       <= S_IDLE;
      acc         <= '0;
      cnt         <= '0;
      dir_left    <= 1'b0;
      sticky      <= 1'b0;
      special     <= 1'b0;
      neg         <= 1'b0;
      spec_data   <= '0;
      spec_st     <= EXACT;
      m_dataOut   <= '0;
      m_statusOut <= EXACT;
    end else begin
      case (state)
        S_IDLE: if (m_validIn) begin
          acc       <= c_special ? '0 : AW'({1'b1, in_m});
          spec_data <= c_data;
          spec_st   <= c_st;
          special   <= c_special;
          neg       <= in_s;
          cnt       <= c_k;
          dir_left  <= c_left;
          sticky    <= 1'b0;
          state     <= S_ALIGN;
        end
        S_ALIGN: begin
          if (cnt != '0) begin
            if (dir_left) begin
              acc <= {acc[AW-2:0], 1'b0};
            end else begin
              acc    <= {1'b0, acc[AW-1:1]};
              sticky <= sticky | acc[0];
            end
            cnt <= cnt - 1'b1;
          end else begin
            state <= S_SIGN;
          end
        end
        S_SIGN: begin
          if (special) begin
            m_dataOut   <= spec_data;
            m_statusOut <= spec_st;
          end else begin
            m_dataOut   <= neg ? (~mag_ext + 1'b1) : mag_ext;
            m_statusOut <= sticky ? INEXACT : EXACT;
          end
          state <= S_DONE;
        end
        default: if (m_readyIn) state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fpu_to_int_converter.sv
// Self-checking bench: a behavioural conversion model feeds an expectation
// queue on every accept; one negedge monitor checks outputs every cycle.
module tb_fpu_to_int_converter;
  import FPU_types::*;

  logic        m_clk = 1'b0;
  logic        m_reset, m_validIn, m_readyIn;
  logic        m_readyOut, m_validOut;
  logic [31:0] m_dataIn, m_dataOut;
  g_eStatus    m_statusOut;

  fpu_to_int_converter dut (
    .m_clk(m_clk), .m_reset(m_reset), .m_validIn(m_validIn),
    .m_readyOut(m_readyOut), .m_dataIn(m_dataIn), .m_validOut(m_validOut),
    .m_readyIn(m_readyIn), .m_dataOut(m_dataOut), .m_statusOut(m_statusOut)
  );

  always #5 m_clk = ~m_clk;

  int nchk = 0, nerr = 0, cyc = 0;
  always @(posedge m_clk) cyc++;

  task automatic chk(input bit ok, input string name, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (!ok) begin
      nerr++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // value = sig * 2^(E-20), truncated toward zero
  task automatic model(input logic [31:0] x, output logic [31:0] d, output g_eStatus st, output int k);
    bit s; int ef, e; longint m, sig, v, dv;
    s = x[31]; ef = int'(x[30:20]); m = longint'(x[19:0]); e = ef - 1023;
    d = 0; st = EXACT; k = 0;
    if (ef == 0) st = (m == 0) ? EXACT : UNDERFLOW;
    else if (ef == 2047 || e > 31 || (e == 31 && !(s && m == 0))) begin
      d = s ? 32'h8000_0000 : 32'h7FFF_FFFF; st = OVERFLOW;
    end else if (e == 31) d = 32'h8000_0000;
    else if (e < 0) st = INEXACT;
    else begin
      sig = 64'd1048576 + m;
      if (e >= 20) begin k = e - 20; v = sig * (64'd1 << k); end
      else begin
        k = 20 - e; dv = 64'd1 << k; v = sig / dv;
        if (sig % dv != 0) st = INEXACT;
      end
      if (s) v = -v;
      d = v[31:0];
    end
  endtask

  typedef struct { logic [31:0] d; g_eStatus st; int k; int acc; } exp_t;
  exp_t q[$];
  bit rst_prev = 0, have_last = 0, seen_valid = 0;
  logic [31:0] last_d;
  g_eStatus last_st;

  // compare process: check current outputs, then account for the coming edge
  always @(negedge m_clk) begin
    exp_t e, n;
    if (rst_prev) begin
      chk(m_validOut == 1'b0, "rst_valid", 32'(m_validOut), 0);
      chk(m_readyOut == 1'b1, "rst_ready", 32'(m_readyOut), 1);
      chk(m_dataOut == 32'h0, "rst_data", m_dataOut, 0);
      chk(m_statusOut == EXACT, "rst_status", 32'(m_statusOut), 32'(EXACT));
    end
    rst_prev = m_reset;
    if (m_validOut === 1'b1) begin
      if (q.size() == 0) chk(0, "spurious_valid", m_dataOut, 0);
      else begin
        e = q[0];
        if (!seen_valid) begin
          chk(cyc - e.acc == e.k + 2, "latency", 32'(cyc - e.acc), 32'(e.k + 2));
          seen_valid = 1;
        end
        chk(m_dataOut == e.d, "data", m_dataOut, e.d);
        chk(m_statusOut == e.st, "status", 32'(m_statusOut), 32'(e.st));
        chk(m_readyOut == 1'b0, "ready_in_done", 32'(m_readyOut), 0);
      end
    end else if (q.size() > 0) begin
      chk(m_readyOut == 1'b0, "ready_busy", 32'(m_readyOut), 0);
      if (cyc - q[0].acc > 30) begin
        chk(0, "result_timeout", 32'(cyc - q[0].acc), 32'(q[0].k + 2));
        q.delete();
      end
    end else if (have_last) begin
      chk(m_readyOut == 1'b1, "ready_idle", 32'(m_readyOut), 1);
      chk(m_dataOut == last_d, "data_hold", m_dataOut, last_d);
      chk(m_statusOut == last_st, "status_hold", 32'(m_statusOut), 32'(last_st));
    end
    if (m_reset) begin
      q.delete(); seen_valid = 0; have_last = 1; last_d = 0; last_st = EXACT;
    end else if (m_validOut === 1'b1 && m_readyIn && q.size() > 0) begin
      last_d = q[0].d; last_st = q[0].st; void'(q.pop_front()); seen_valid = 0;
    end else if (m_validIn && m_readyOut === 1'b1) begin
      model(m_dataIn, n.d, n.st, n.k); n.acc = cyc + 1; q.push_back(n);
    end
  end

  task automatic step(); @(posedge m_clk); #1; endtask

  task automatic send(input logic [31:0] x);
    int n = 0;
    while (!m_readyOut && n < 50) begin step(); n++; end
    m_validIn = 1; m_dataIn = x; step(); m_validIn = 0;
  endtask

  task automatic wait_valid();
    int n = 0;
    while (!m_validOut && n < 50) begin step(); n++; end
    if (!m_validOut) chk(0, "wait_valid", 0, 1);
  endtask

  logic [31:0] dir_vec [10] = '{32'h40040000, 32'h3FF00000, 32'hC0080000, 32'h41D00001,
    32'hC1E00000, 32'h42700000, 32'hC2700000, 32'h00000001, 32'h3FE00000, 32'h80000000};
  logic [31:0] pin_d [10] = '{32'h00000002, 32'h00000001, 32'hFFFFFFFD, 32'h40000400,
    32'h80000000, 32'h7FFFFFFF, 32'h80000000, 32'h0, 32'h0, 32'h0};
  g_eStatus pin_s [10] = '{INEXACT, EXACT, EXACT, EXACT, EXACT, OVERFLOW, OVERFLOW,
    UNDERFLOW, INEXACT, EXACT};

  initial begin
    logic [31:0] md; g_eStatus ms; int mk;
    m_reset = 1; m_validIn = 0; m_readyIn = 1; m_dataIn = 0;
    // pin the model against hand-computed values
    for (int i = 0; i < 10; i++) begin
      model(dir_vec[i], md, ms, mk);
      chk(md == pin_d[i], "model_data", md, pin_d[i]);
      chk(ms == pin_s[i], "model_status", 32'(ms), 32'(pin_s[i]));
    end
    model(32'h40040000, md, ms, mk); chk(mk == 19, "model_k_right", 32'(mk), 19);
    model(32'h42700000, md, ms, mk); chk(mk == 0, "model_k_special", 32'(mk), 0);
    model(32'h41D00001, md, ms, mk); chk(mk == 10, "model_k_left", 32'(mk), 10);

    repeat (3) step();
    m_reset = 0; step();

    // reset while aligning: operand must vanish
    send(32'h40040000);
    repeat (5) step();
    m_reset = 1; step(); m_reset = 0;
    repeat (30) step();

    // directed conversions with immediate acceptance
    for (int i = 0; i < 10; i++) begin
      send(dir_vec[i]); wait_valid(); step();
    end

    // back-pressure: hold in DONE for 3 cycles
    m_readyIn = 0;
    send(32'h3FF00000); wait_valid();
    repeat (3) step();
    m_readyIn = 1; step();

    // continuous valid: one conversion per accept
    m_validIn = 1; m_dataIn = 32'h3FF00000;
    repeat (40) step();
    m_validIn = 0;
    repeat (5) step();

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      int r; logic [10:0] ef;
      r = int'($urandom_range(0, 7));
      if (r == 0) ef = 11'd0;
      else if (r == 1) ef = 11'h7FF;
      else ef = 11'(1000 + $urandom_range(0, 59));
      m_dataIn = {1'($urandom), ef, ($urandom_range(0, 3) == 0) ? 20'h0 : 20'($urandom)};
      m_validIn = 1'($urandom);
      m_readyIn = ($urandom_range(0, 3) != 0);
      if (i == 1500) m_reset = 1; else m_reset = 0;
      step();
    end
    m_validIn = 0; m_readyIn = 1; m_reset = 0;
    repeat (40) step();
    chk(q.size() == 0, "drain_empty", 32'(q.size()), 0);

    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end
endmodule
